// File: rtl/priority_encoder_sync.sv
// rtl/priority_encoder_sync.sv - registered highest-index-wins priority encoder (optional PRIO_MASK_EN adds a request mask)
module priority_encoder_sync #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [WIDTH-1:0]         in,
`ifdef PRIO_MASK_EN
    input  logic [WIDTH-1:0]         mask,
`endif
    output logic [$clog2(WIDTH)-1:0] out,
    output logic                     valid,
    output logic [WIDTH-1:0]         grant
);

    localparam int OUT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] req;
    logic [OUT_W-1:0] idx;
    logic             any;
    logic [WIDTH-1:0] grant_next;

    // Effective request vector: masked requests never reach the encoder.
    always_comb begin
`ifdef PRIO_MASK_EN
        req = in & ~mask;
`else
        req = in;
`endif
    end

    // Ascending scan so the last (highest) set bit overwrites lower ones;
    // an all-zero vector leaves idx at 0 and grant empty.
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = 0; i < WIDTH; i++) begin
            if (req[i]) begin
                idx = i[OUT_W-1:0];
            end
        end
        grant_next = any ? (WIDTH'(1) << idx) : '0;
    end

    // Output registers: capture on en, hold otherwise; reset clears without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            valid <= 1'b0;
            grant <= '0;
        end else if (en) begin
            out   <= idx;
            valid <= any;
            grant <= grant_next;
        end
    end

endmodule

// File: tb/tb_priority_encoder_sync.sv
// tb/tb_priority_encoder_sync.sv - directed bench for priority_encoder_sync at WIDTH 4 and 8
module tb_priority_encoder_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] in4;
    logic [1:0] out4;
    logic       valid4;
    logic [3:0] grant4;
    logic [7:0] in8;
    logic [2:0] out8;
    logic       valid8;
    logic [7:0] grant8;
`ifdef PRIO_MASK_EN
    logic [3:0] mask4;
    logic [7:0] mask8;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    priority_encoder_sync #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in    (in4),
`ifdef PRIO_MASK_EN
        .mask  (mask4),
`endif
        .out   (out4),
        .valid (valid4),
        .grant (grant4)
    );

    priority_encoder_sync #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in    (in8),
`ifdef PRIO_MASK_EN
        .mask  (mask8),
`endif
        .out   (out8),
        .valid (valid8),
        .grant (grant8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({out4, valid4, grant4} !== 7'b00_0_0000) begin
            errors++;
            $display("FAIL reset_initial got out=%b valid=%b grant=%b want 00 0 0000", out4, valid4, grant4);
        end
        en  = 1'b1;
        in4 = 4'b1000;
        tick();
        checks++;
        if ({out4, valid4, grant4} !== 7'b00_0_0000) begin
            errors++;
            $display("FAIL reset_edge_ignored got out=%b valid=%b grant=%b want 00 0 0000", out4, valid4, grant4);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({out4, valid4, grant4} !== 7'b11_1_1000) begin
            errors++;
            $display("FAIL first_capture got out=%b valid=%b grant=%b want 11 1 1000", out4, valid4, grant4);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out4, valid4, grant4} !== 7'b00_0_0000) begin
            errors++;
            $display("FAIL async_reset got out=%b valid=%b grant=%b want 00 0 0000", out4, valid4, grant4);
        end
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_sequence();
        logic [3:0] vin  [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b1111};
        logic [6:0] vexp [4] = '{7'b00_0_0000, 7'b00_1_0001, 7'b01_1_0010, 7'b11_1_1000};
        logic [6:0] prev;
        en   = 1'b1;
        prev = {out4, valid4, grant4};
        for (int k = 0; k < 4; k++) begin
            in4 = vin[k];
            #1;
            checks++;
            if ({out4, valid4, grant4} !== prev) begin
                errors++;
                $display("FAIL seq_latency[%0d] got %b want %b", k, {out4, valid4, grant4}, prev);
            end
            tick();
            checks++;
            if ({out4, valid4, grant4} !== vexp[k]) begin
                errors++;
                $display("FAIL seq[%0d] in=%b got out=%b valid=%b grant=%b want %b", k, vin[k], out4, valid4, grant4, vexp[k]);
            end
            prev = vexp[k];
        end
    endtask

    task automatic test_hold();
        en  = 1'b1;
        in4 = 4'b0100;
        tick();
        checks++;
        if ({out4, valid4, grant4} !== 7'b10_1_0100) begin
            errors++;
            $display("FAIL hold_capture got out=%b valid=%b grant=%b want 10 1 0100", out4, valid4, grant4);
        end
        en  = 1'b0;
        in4 = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({out4, valid4, grant4} !== 7'b10_1_0100) begin
                errors++;
                $display("FAIL hold[%0d] got out=%b valid=%b grant=%b want 10 1 0100", k, out4, valid4, grant4);
            end
        end
    endtask

    task automatic test_exhaustive4();
        logic [1:0] eout [16] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                                  2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        logic [3:0] egrant;
        logic       evalid;
        en = 1'b1;
        for (int v = 0; v < 16; v++) begin
            in4    = v[3:0];
            evalid = (v != 0);
            egrant = evalid ? (4'b0001 << eout[v]) : 4'b0000;
            tick();
            checks++;
            if ({out4, valid4, grant4} !== {eout[v], evalid, egrant}) begin
                errors++;
                $display("FAIL exh4 in=%b got out=%b valid=%b grant=%b want %b %b %b", in4, out4, valid4, grant4, eout[v], evalid, egrant);
            end
        end
    endtask

    task automatic test_width8();
        logic [7:0]  vin  [6] = '{8'b1000_0001, 8'b0000_0001, 8'b0000_0000, 8'b0011_1100, 8'b0100_0000, 8'b1111_1111};
        logic [11:0] vexp [6] = '{{3'd7, 1'b1, 8'b1000_0000}, {3'd0, 1'b1, 8'b0000_0001},
                                  {3'd0, 1'b0, 8'b0000_0000}, {3'd5, 1'b1, 8'b0010_0000},
                                  {3'd6, 1'b1, 8'b0100_0000}, {3'd7, 1'b1, 8'b1000_0000}};
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in8 = vin[k];
            tick();
            checks++;
            if ({out8, valid8, grant8} !== vexp[k]) begin
                errors++;
                $display("FAIL w8[%0d] in=%b got out=%b valid=%b grant=%b want %b", k, vin[k], out8, valid8, grant8, vexp[k]);
            end
        end
    endtask

`ifdef PRIO_MASK_EN
    task automatic test_mask();
        en    = 1'b1;
        in4   = 4'b1111;
        mask4 = 4'b1000;
        tick();
        checks++;
        if ({out4, valid4, grant4} !== 7'b10_1_0100) begin
            errors++;
            $display("FAIL mask_msb got out=%b valid=%b grant=%b want 10 1 0100", out4, valid4, grant4);
        end
        in4   = 4'b0001;
        mask4 = 4'b0001;
        tick();
        checks++;
        if ({out4, valid4, grant4} !== 7'b00_0_0000) begin
            errors++;
            $display("FAIL mask_all got out=%b valid=%b grant=%b want 00 0 0000", out4, valid4, grant4);
        end
        mask4 = 4'b0000;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        in4   = 4'b0000;
        in8   = 8'h00;
`ifdef PRIO_MASK_EN
        mask4 = 4'b0000;
        mask8 = 8'h00;
`endif
        test_reset();
        test_sequence();
        test_hold();
        test_exhaustive4();
        test_width8();
`ifdef PRIO_MASK_EN
        test_mask();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
